// File: rtl/tengbe_tx_pkg.sv
// Shared types and constants for the 10GbE transmit frame sender.
package tengbe_tx_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWaitAck,
    StStream,
    StDrain,
    StIfg
  } tx_state_e;

  localparam logic [63:0] IDLE_WORD = 64'h0707070707070707;
  localparam logic [7:0]  MASK_NONE = 8'h00;
  localparam logic [7:0]  MASK_FULL = 8'hFF;

endpackage

// File: rtl/tengbe_tx_frame_sender_if.sv
// Buffer-side and MAC-side signals of the transmit frame sender.
interface tengbe_tx_frame_sender_if;

  logic [63:0] buf_data;
  logic [7:0]  buf_mask;
  logic        buf_eof;
  logic        buf_empty;
  logic        buf_rd;
  logic        frm_commit;
  logic [63:0] tx_data;
  logic [7:0]  tx_data_valid;
  logic        tx_start;
  logic        tx_ack;
  logic        tx_underrun;
  logic        busy;
  logic [31:0] frames_sent;
  logic [15:0] underrun_cnt;
  logic        frm_ovf;

  modport master (
    input  buf_data, buf_mask, buf_eof, buf_empty, frm_commit, tx_ack,
    output buf_rd, tx_data, tx_data_valid, tx_start, tx_underrun, busy,
           frames_sent, underrun_cnt, frm_ovf
  );

  modport slave (
    output buf_data, buf_mask, buf_eof, buf_empty, frm_commit, tx_ack,
    input  buf_rd, tx_data, tx_data_valid, tx_start, tx_underrun, busy,
           frames_sent, underrun_cnt, frm_ovf
  );

endinterface

// File: rtl/tengbe_tx_pending_cnt.sv
// Saturating count of committed-but-unsent frames, with a sticky overflow flag.
module tengbe_tx_pending_cnt #(
  parameter int unsigned Width = 8
) (
  input  logic             tx_clk0,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [Width-1:0] count,
  output logic             ovf
);

  localparam logic [Width-1:0] CntMax = '1;

  logic [Width-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    // A simultaneous commit and dequeue cancel out, even when saturated.
    if (inc && !dec) begin
      if (count_q == CntMax) ovf_d = 1'b1;
      else                   count_d = count_q + Width'(1);
    end else if (dec && !inc && count_q != '0) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge tx_clk0) begin
    if (reset) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign ovf   = ovf_q;

endmodule

// File: rtl/tengbe_tx_frame_sender.sv
// Transmit sequencer: streams committed frames from a FWFT buffer to the 10GbE MAC client
// interface, enforcing the inter-frame gap and aborting frames on buffer underrun.
module tengbe_tx_frame_sender
  import tengbe_tx_pkg::*;
#(
  parameter int unsigned IFG_CYCLES = 3,
  parameter int unsigned FRM_CNT_W  = 8
) (
  input logic                      tx_clk0,
  input logic                      reset,
  tengbe_tx_frame_sender_if.master bus
);

  localparam logic [7:0] IfgLoad = 8'(IFG_CYCLES - 1);

  tx_state_e            state_q, state_d;
  logic                 last_q, last_d;
  logic [7:0]           ifg_cnt_q, ifg_cnt_d;
  logic [63:0]          data_q, data_d;
  logic [7:0]           mask_q, mask_d;
  logic                 start_q, start_d;
  logic                 underrun_q, underrun_d;
  logic                 busy_q;
  logic [31:0]          frames_q, frames_d;
  logic [15:0]          urun_q, urun_d;
  logic                 pop, leave_idle, stream_cycle;
  logic [FRM_CNT_W-1:0] pending;
  logic                 ovf;

  tengbe_tx_pending_cnt #(
    .Width (FRM_CNT_W)
  ) u_pending (
    .tx_clk0 (tx_clk0),
    .reset   (reset),
    .inc     (bus.frm_commit),
    .dec     (leave_idle),
    .count   (pending),
    .ovf     (ovf)
  );

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    ifg_cnt_d    = ifg_cnt_q;
    data_d       = data_q;
    mask_d       = mask_q;
    start_d      = 1'b0;
    underrun_d   = 1'b0;
    frames_d     = frames_q;
    urun_d       = urun_q;
    pop          = 1'b0;
    leave_idle   = 1'b0;
    stream_cycle = 1'b0;

    unique case (state_q)
      StIdle: begin
        data_d = IDLE_WORD;
        mask_d = MASK_NONE;
        if (pending != '0 && !bus.buf_empty) begin
          pop        = 1'b1;
          leave_idle = 1'b1;
          data_d     = bus.buf_data;
          mask_d     = bus.buf_mask;
          start_d    = 1'b1;
          last_d     = bus.buf_eof;
          state_d    = StWaitAck;
        end
      end
      StWaitAck: begin
        if (bus.tx_ack) begin
          if (last_q) begin
            data_d    = IDLE_WORD;
            mask_d    = MASK_NONE;
            frames_d  = frames_q + 32'd1;
            ifg_cnt_d = IfgLoad;
            state_d   = StIfg;
          end else begin
            stream_cycle = 1'b1;
          end
        end
      end
      StStream: stream_cycle = 1'b1;
      StDrain: begin
        data_d = IDLE_WORD;
        mask_d = MASK_NONE;
        if (!bus.buf_empty) begin
          pop = 1'b1;
          if (bus.buf_eof) begin
            ifg_cnt_d = IfgLoad;
            state_d   = StIfg;
          end
        end
      end
      StIfg: begin
        data_d = IDLE_WORD;
        mask_d = MASK_NONE;
        if (ifg_cnt_q == 8'd0) state_d = StIdle;
        else                   ifg_cnt_d = ifg_cnt_q - 8'd1;
      end
      default: state_d = StIdle;
    endcase

    if (stream_cycle) begin
      if (!bus.buf_empty) begin
        pop    = 1'b1;
        data_d = bus.buf_data;
        mask_d = bus.buf_mask;
        if (bus.buf_eof) begin
          frames_d  = frames_q + 32'd1;
          ifg_cnt_d = IfgLoad;
          state_d   = StIfg;
        end else begin
          state_d = StStream;
        end
      end else begin
        // Dropping valid to 00 mid-frame is what tells the MAC the frame is aborted.
        data_d     = IDLE_WORD;
        mask_d     = MASK_NONE;
        underrun_d = 1'b1;
        if (urun_q != 16'hFFFF) urun_d = urun_q + 16'd1;
        state_d    = StDrain;
      end
    end
  end

  always_ff @(posedge tx_clk0) begin
    if (reset) begin
      state_q    <= StIdle;
      last_q     <= 1'b0;
      ifg_cnt_q  <= 8'd0;
      data_q     <= '0;
      mask_q     <= MASK_NONE;
      start_q    <= 1'b0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
      frames_q   <= '0;
      urun_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      ifg_cnt_q  <= ifg_cnt_d;
      data_q     <= data_d;
      mask_q     <= mask_d;
      start_q    <= start_d;
      underrun_q <= underrun_d;
      busy_q     <= (state_d != StIdle);
      frames_q   <= frames_d;
      urun_q     <= urun_d;
    end
  end

  // The pop is decided in the cycle the FWFT head is consumed so words can stream back to back.
  assign bus.buf_rd        = pop && !reset;
  assign bus.tx_data       = data_q;
  assign bus.tx_data_valid = mask_q;
  assign bus.tx_start      = start_q;
  assign bus.tx_underrun   = underrun_q;
  assign bus.busy          = busy_q;
  assign bus.frames_sent   = frames_q;
  assign bus.underrun_cnt  = urun_q;
  assign bus.frm_ovf       = ovf;

endmodule
